// File: rtl/present_dec_pkg.sv
// Shared definitions for the PRESENT-80 decryption core: round count,
// FSM encoding and the forward/inverse 4-bit S-boxes.
package present_dec_pkg;

  localparam int ROUNDS_80 = 31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    DEC    = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Tables are listed nibble 0 first, so entry x sits at bits [63-4x -: 4].
  localparam logic [63:0] S_TAB    = 64'hC56B90AD3EF84712;
  localparam logic [63:0] INVS_TAB = 64'h5EF8C12DB463079A;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = S_TAB << {x, 2'b00};
    return t[63:60];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [63:0] t;
    t = INVS_TAB << {x, 2'b00};
    return t[63:60];
  endfunction

endpackage

// File: rtl/present_dec_round.sv
// One inverse PRESENT round: key add, inverse P-layer, inverse S-layer,
// plus the step that walks the key register back from K(r+1) to K(r).
module present_dec_round
  import present_dec_pkg::*;
(
  input  logic [63:0] s_i,
  input  logic [79:0] kr_i,
  input  logic [4:0]  cnt_i,
  output logic [63:0] s_o,
  output logic [79:0] kr_o
);

  logic [63:0] x;
  logic [63:0] p;
  logic [79:0] t;

  assign x = s_i ^ kr_i[79:16];

  // Forward P moves bit i to 16*i mod 63, so the inverse gathers from there.
  for (genvar i = 0; i < 63; i++) begin : g_invp
    assign p[i] = x[(16 * i) % 63];
  end
  assign p[63] = x[63];

  for (genvar n = 0; n < 16; n++) begin : g_invs
    assign s_o[4*n +: 4] = inv_sbox(p[4*n +: 4]);
  end

  // Undo the forward update in reverse order: counter xor, S-box, rotation.
  always_comb begin
    t          = kr_i;
    t[19:15]   = t[19:15] ^ cnt_i;
    t[79:76]   = inv_sbox(t[79:76]);
  end

  assign kr_o = {t[60:0], t[79:61]};

endmodule

// File: rtl/present_dec.sv
// Iterative PRESENT-80 decryption: forward key expansion to K32, then one
// inverse round per cycle, result returned over a 4-phase req/ack handshake.
module present_dec
  import present_dec_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [79:0] k,
  input  logic [63:0] c,
  output logic        ack,
  output logic [63:0] m
);

  localparam logic [4:0] LAST = 5'(ROUNDS);

  state_e      state_q;
  logic [63:0] s_q;
  logic [79:0] kr_q;
  logic [4:0]  cnt_q;

  logic [79:0] kr_fwd_d;
  logic [63:0] s_dec_d;
  logic [79:0] kr_dec_d;

  always_comb begin
    kr_fwd_d          = {kr_q[18:0], kr_q[79:19]};
    kr_fwd_d[79:76]   = sbox(kr_fwd_d[79:76]);
    kr_fwd_d[19:15]   = kr_fwd_d[19:15] ^ cnt_q;
  end

  present_dec_round u_round (
    .s_i   (s_q),
    .kr_i  (kr_q),
    .cnt_i (cnt_q),
    .s_o   (s_dec_d),
    .kr_o  (kr_dec_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      kr_q    <= '0;
      cnt_q   <= '0;
      ack     <= 1'b0;
      m       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            s_q     <= c;
            kr_q    <= k;
            cnt_q   <= 5'd1;
            state_q <= KEYEXP;
          end
        end
        KEYEXP: begin
          kr_q <= kr_fwd_d;
          // The last forward step leaves cnt at ROUNDS, the first DEC round index.
          if (cnt_q == LAST) state_q <= DEC;
          else               cnt_q   <= cnt_q + 5'd1;
        end
        DEC: begin
          s_q   <= s_dec_d;
          kr_q  <= kr_dec_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= FINAL;
        end
        FINAL: begin
          m       <= s_q ^ kr_q[79:16];
          ack     <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (!req) begin
            ack     <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec.sv
// Self-checking bench for present_dec: known-answer table, handshake corner
// cases and mid-operation reset, with a queue of expected plaintexts.
module tb_present_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [79:0] k_r;
  logic [63:0] c_r;
  logic        ack;
  logic [63:0] m;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [79:0] k;
    logic [63:0] c;
    logic [63:0] m;
  } vec_t;

  vec_t vecs[4];
  logic [63:0] exp_q[$];

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  present_dec dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .k   (k_r),
    .c   (c_r),
    .ack (ack),
    .m   (m)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for ack; optionally drop req at edge
  // drop_at and/or corrupt c after acceptance.
  task automatic run_op(input string name, input logic [79:0] key, input logic [63:0] ct,
                        input logic [63:0] pt, input int drop_at, input bit mut_c);
    int j;
    logic [63:0] exp;
    k_r = key;
    c_r = ct;
    req = 1'b1;
    exp_q.push_back(pt);
    tick();  // E0: accepted
    j = 0;
    while (!ack && j < 100) begin
      if (j == drop_at) req = 1'b0;
      if (mut_c && j == 1) begin
        c_r = ~c_r;
        k_r = ~k_r;
      end
      tick();
      j++;
    end
    check({name, " latency"}, 64'(j), 64'd63);
    exp = exp_q.pop_front();
    check({name, " m"}, m, exp);
  endtask

  task automatic release_req(input string name);
    req = 1'b0;
    tick();
    check({name, " ack low after release"}, 64'(ack), 64'd0);
  endtask

  initial begin
    int cnt_ok;
    logic [63:0] m_hold;

    vecs[0] = '{k: K0, c: 64'h5579C1387B228445, m: 64'h0000000000000000};
    vecs[1] = '{k: K1, c: 64'hE72C46C0F5945049, m: 64'h0000000000000000};
    vecs[2] = '{k: K0, c: 64'hA112FFC72F68417B, m: 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{k: K1, c: 64'h3333DCD3213210D2, m: 64'hFFFFFFFFFFFFFFFF};

    rst = 1'b1;
    req = 1'b0;
    k_r = '0;
    c_r = '0;
    tick();
    tick();
    check("reset ack", 64'(ack), 64'd0);
    check("reset m", m, 64'd0);
    rst = 1'b0;
    cnt_ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack === 1'b0) cnt_ok++;
    end
    check("idle ack low cycles", 64'(cnt_ok), 64'd10);

    // Table vectors back-to-back, req low for exactly one edge between them.
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i + 1), vecs[i].k, vecs[i].c, vecs[i].m, -1, 1'b0);
      release_req($sformatf("vec%0d", i + 1));
    end

    // req held high: ack and m must stay put, no restart.
    run_op("hold", vecs[1].k, vecs[1].c, vecs[1].m, -1, 1'b0);
    m_hold = m;
    cnt_ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack === 1'b1 && m === m_hold) cnt_ok++;
    end
    check("hold ack/m stable cycles", 64'(cnt_ok), 64'd100);
    release_req("hold");
    check("hold m retained in idle", m, m_hold);

    // req dropped at E10 and operands changed after E0: 1-cycle ack pulse.
    run_op("drop", vecs[2].k, vecs[2].c, vecs[2].m, 10, 1'b1);
    tick();
    check("drop ack pulse width", 64'(ack), 64'd0);
    tick();
    check("drop stays idle", 64'(ack), 64'd0);

    // Reset during KEYEXP (E30) and during DEC (E45).
    for (int r = 0; r < 2; r++) begin
      int at;
      at = (r == 0) ? 30 : 45;
      k_r = vecs[3].k;
      c_r = vecs[3].c;
      req = 1'b1;
      tick();  // E0
      for (int j = 1; j < at; j++) tick();
      rst = 1'b1;
      req = 1'b0;
      tick();  // reset edge
      check($sformatf("rst@E%0d ack", at), 64'(ack), 64'd0);
      check($sformatf("rst@E%0d m", at), m, 64'd0);
      rst = 1'b0;
      tick();
    end
    run_op("post-reset vec1", vecs[0].k, vecs[0].c, vecs[0].m, -1, 1'b0);
    release_req("post-reset vec1");

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
